// File: rtl/data_mem_io_if.sv
// Processor-side data bus: word address, write data, write strobe and
// registered read data returned by the memory responder.
interface data_mem_io_if #(
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int MEM_DATA_WIDTH = 8
);
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [MEM_DATA_WIDTH-1:0] mem_wdata;
    logic                      mem_WE;
    logic [MEM_DATA_WIDTH-1:0] mem_rdata;

    modport master (output mem_addr, output mem_wdata, output mem_WE, input mem_rdata);
    modport slave  (input mem_addr, input mem_wdata, input mem_WE, output mem_rdata);
endinterface

// File: rtl/data_mem_io.sv
// Data RAM plus a 4-register I/O window (GPIO out, synchronised GPIO in,
// prescaled timer count, timer control/status) at the top of the address map.
module data_mem_io #(
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int MEM_DATA_WIDTH = 8,
    parameter int IO_BASE        = 2**MEM_ADDR_WIDTH - 4,
    parameter int TMR_DIV        = 4
) (
    input  logic                      clk,
    input  logic                      srst_n,
    data_mem_io_if.slave              bus,
    input  logic [MEM_DATA_WIDTH-1:0] gpio_i,
    output logic [MEM_DATA_WIDTH-1:0] gpio_o,
    output logic                      irq
);
    localparam int AW = MEM_ADDR_WIDTH;
    localparam int DW = MEM_DATA_WIDTH;
    localparam int PW = (TMR_DIV > 1) ? $clog2(TMR_DIV) : 1;
    localparam logic [AW-1:0] IO_BASE_A = AW'(IO_BASE);
    localparam logic [PW-1:0] PRE_LAST  = PW'(TMR_DIV - 1);

    // Address decode
    logic       is_io;
    logic [1:0] io_sel;
    logic       wr_gpio, wr_cnt, wr_ctrl;

    assign is_io   = (bus.mem_addr >= IO_BASE_A);
    assign io_sel  = 2'(bus.mem_addr - IO_BASE_A);
    assign wr_gpio = bus.mem_WE && is_io && (io_sel == 2'd0);
    assign wr_cnt  = bus.mem_WE && is_io && (io_sel == 2'd2);
    assign wr_ctrl = bus.mem_WE && is_io && (io_sel == 2'd3);

    // RAM: single port, read-first, contents untouched by reset
    logic [DW-1:0] ram [IO_BASE];
    logic [DW-1:0] ram_rd_reg;

    // RAM write and registered read; a write presented during reset is dropped
    always_ff @(posedge clk) begin
        if (srst_n && bus.mem_WE && !is_io)
            ram[bus.mem_addr] <= bus.mem_wdata;
        ram_rd_reg <= ram[bus.mem_addr];
    end

    // Two-flop synchroniser for the external inputs, one chain per bit
    logic [DW-1:0] sync1_reg, sync2_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DW; gi++) begin : g_sync
            // Per-bit synchroniser chain
            always_ff @(posedge clk) begin
                if (!srst_n) begin
                    sync1_reg[gi] <= 1'b0;
                    sync2_reg[gi] <= 1'b0;
                end else begin
                    sync1_reg[gi] <= gpio_i[gi];
                    sync2_reg[gi] <= sync1_reg[gi];
                end
            end
        end
    endgenerate

    // I/O register state
    logic [DW-1:0] gpio_o_reg, gpio_o_next;
    logic [DW-1:0] cnt_reg, cnt_next;
    logic [PW-1:0] pre_reg, pre_next;
    logic          en_reg, en_next;
    logic          irq_en_reg, irq_en_next;
    logic          tov_reg, tov_next;
    logic          irq_reg;
    logic          tick;
    logic          tov_set;

    assign tick = en_reg && (pre_reg == PRE_LAST);
    // A count write in the tick cycle overrides the increment, so no overflow either
    assign tov_set = tick && (cnt_reg == '1) && !wr_cnt;

    // Next-state for GPIO out, prescaler, count and control/status bits
    always_comb begin
        gpio_o_next = gpio_o_reg;
        cnt_next    = cnt_reg;
        pre_next    = pre_reg;
        en_next     = en_reg;
        irq_en_next = irq_en_reg;
        tov_next    = tov_reg;

        if (wr_gpio)
            gpio_o_next = bus.mem_wdata;

        if (tick) begin
            pre_next = '0;
            cnt_next = cnt_reg + 1'b1;
        end else if (en_reg) begin
            pre_next = pre_reg + 1'b1;
        end

        if (wr_cnt) begin
            cnt_next = bus.mem_wdata;
            pre_next = '0;
        end

        if (wr_ctrl) begin
            en_next     = bus.mem_wdata[0];
            irq_en_next = bus.mem_wdata[1];
            if (bus.mem_wdata[DW-1])
                tov_next = 1'b0;
        end

        // Setting the overflow flag beats a simultaneous write-1-clear
        if (tov_set)
            tov_next = 1'b1;
    end

    // I/O read value: timer registers report their post-edge contents
    logic [DW-1:0] io_rd_next, io_rd_reg;
    logic          ram_sel_reg;

    always_comb begin
        io_rd_next = '0;
        case (io_sel)
            2'd0: io_rd_next = gpio_o_reg;
            2'd1: io_rd_next = sync2_reg;
            2'd2: io_rd_next = cnt_next;
            default: begin
                io_rd_next[0]    = en_next;
                io_rd_next[1]    = irq_en_next;
                io_rd_next[DW-1] = tov_next;
            end
        endcase
    end

    // State registers, read-path registers and the interrupt flop
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            gpio_o_reg  <= '0;
            cnt_reg     <= '0;
            pre_reg     <= '0;
            en_reg      <= 1'b0;
            irq_en_reg  <= 1'b0;
            tov_reg     <= 1'b0;
            irq_reg     <= 1'b0;
            io_rd_reg   <= '0;
            ram_sel_reg <= 1'b0;
        end else begin
            gpio_o_reg  <= gpio_o_next;
            cnt_reg     <= cnt_next;
            pre_reg     <= pre_next;
            en_reg      <= en_next;
            irq_en_reg  <= irq_en_next;
            tov_reg     <= tov_next;
            irq_reg     <= tov_reg && irq_en_reg;
            io_rd_reg   <= io_rd_next;
            ram_sel_reg <= !is_io;
        end
    end

    // Both read sources are registered; the select flop resets to the I/O side,
    // whose register is cleared, so read data is zero after reset
    assign bus.mem_rdata = ram_sel_reg ? ram_rd_reg : io_rd_reg;
    assign gpio_o        = gpio_o_reg;
    assign irq           = irq_reg;
endmodule

// File: tb/tb_data_mem_io.sv
// Directed bench for data_mem_io: one bus transaction per clock, expected
// read data queued when the address is driven and checked after the edge.
module tb_data_mem_io;
    logic       clk;
    logic       srst_n;
    logic [7:0] gpio_i;
    logic [7:0] gpio_o;
    logic       irq;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         chk;
        logic [7:0] exp;
        string      tag;
    } exp_t;

    exp_t sb_q[$];

    data_mem_io_if #(.MEM_ADDR_WIDTH(8), .MEM_DATA_WIDTH(8)) bus_if ();

    data_mem_io #(
        .MEM_ADDR_WIDTH(8),
        .MEM_DATA_WIDTH(8),
        .IO_BASE(252),
        .TMR_DIV(4)
    ) dut (
        .clk(clk),
        .srst_n(srst_n),
        .bus(bus_if),
        .gpio_i(gpio_i),
        .gpio_o(gpio_o),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive, queue the expectation, clock, pop and compare
    task automatic bus(input logic [7:0] a, input bit we, input logic [7:0] wd,
                       input bit chk, input logic [7:0] exp, input string tag);
        exp_t e;
        bus_if.mem_addr  = a;
        bus_if.mem_WE    = we;
        bus_if.mem_wdata = wd;
        e.chk = chk;
        e.exp = exp;
        e.tag = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus_if.mem_WE = 1'b0;
        e = sb_q.pop_front();
        $display("txn addr=%h we=%0d wdata=%h rdata=%h gpio_o=%h irq=%0d",
                 a, we, wd, bus_if.mem_rdata, gpio_o, irq);
        if (e.chk)
            check(e.tag, bus_if.mem_rdata, e.exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        srst_n           = 1'b0;
        gpio_i           = 8'hA5;
        bus_if.mem_addr  = 8'h00;
        bus_if.mem_wdata = 8'h00;
        bus_if.mem_WE    = 1'b0;

        // Reset for two cycles
        bus(8'h00, 0, 8'h00, 1, 8'h00, "rst_rdata0");
        bus(8'h00, 0, 8'h00, 1, 8'h00, "rst_rdata1");
        check("rst_gpio_o", gpio_o, 8'h00);
        check("rst_irq", {7'b0, irq}, 8'h00);
        srst_n = 1'b1;
        bus(8'hFF, 0, 8'h00, 1, 8'h00, "rst_ctrl");

        // RAM write / readback
        bus(8'h10, 1, 8'h3C, 0, 8'h00, "ram_wr10");
        bus(8'h11, 1, 8'hC3, 0, 8'h00, "ram_wr11");
        bus(8'h10, 0, 8'h00, 1, 8'h3C, "ram_rd10");
        bus(8'h11, 0, 8'h00, 1, 8'hC3, "ram_rd11");
        bus(8'h10, 1, 8'h55, 1, 8'h3C, "ram_rdw_old");
        bus(8'h10, 0, 8'h00, 1, 8'h55, "ram_rdw_new");

        // GPIO out
        bus(8'hFC, 1, 8'h81, 0, 8'h00, "gpio_wr");
        check("gpio_o_after_wr", gpio_o, 8'h81);
        bus(8'hFC, 0, 8'h00, 1, 8'h81, "gpio_out_rd");

        // GPIO in: the synchroniser has long since settled on A5
        bus(8'hFD, 0, 8'h00, 1, 8'hA5, "gpio_in_a5");
        gpio_i = 8'h5A;
        bus(8'hFD, 0, 8'h00, 1, 8'hA5, "gpio_in_e1");
        bus(8'hFD, 0, 8'h00, 1, 8'hA5, "gpio_in_e2");
        bus(8'hFD, 0, 8'h00, 1, 8'h5A, "gpio_in_e3");
        bus(8'hFD, 1, 8'h00, 0, 8'h00, "gpio_in_wr");
        bus(8'hFD, 0, 8'h00, 1, 8'h5A, "gpio_in_ro");
        check("gpio_o_unchanged", gpio_o, 8'h81);

        // Timer: load FE, enable with IRQ
        bus(8'hFE, 1, 8'hFE, 1, 8'hFE, "tmr_load");
        bus(8'hFF, 1, 8'h03, 1, 8'h03, "tmr_en");
        for (int i = 1; i <= 7; i++)
            bus(8'hFE, 0, 8'h00, 1, (i < 4) ? 8'hFE : 8'hFF, "tmr_cnt");
        bus(8'hFE, 0, 8'h00, 1, 8'h00, "tmr_wrap");
        check("irq_before", {7'b0, irq}, 8'h00);
        bus(8'hFF, 0, 8'h00, 1, 8'h83, "tmr_ctrl_tov");
        check("irq_rise", {7'b0, irq}, 8'h01);

        // Clear TOV with no overflow in progress
        bus(8'hFF, 1, 8'h80, 1, 8'h00, "tov_clear");
        check("irq_still_high", {7'b0, irq}, 8'h01);
        bus(8'hFF, 0, 8'h00, 1, 8'h00, "tov_cleared");
        check("irq_fall", {7'b0, irq}, 8'h00);

        // Clear write landing on the FF->00 tick: set wins
        bus(8'hFE, 1, 8'hFF, 1, 8'hFF, "race_load");
        bus(8'hFF, 1, 8'h03, 1, 8'h03, "race_en");
        for (int i = 1; i <= 3; i++)
            bus(8'hFE, 0, 8'h00, 1, 8'hFF, "race_hold");
        bus(8'hFF, 1, 8'h83, 1, 8'h83, "race_tov_wins");
        bus(8'hFF, 0, 8'h00, 1, 8'h83, "race_tov_stays");
        check("race_irq", {7'b0, irq}, 8'h01);
        bus(8'hFE, 0, 8'h00, 1, 8'h00, "race_cnt");

        // Reset in mid-operation with a write pending
        bus(8'h20, 1, 8'h77, 0, 8'h00, "pre_rst_wr");
        check("pre_rst_irq", {7'b0, irq}, 8'h01);
        srst_n = 1'b0;
        bus(8'h20, 1, 8'hEE, 1, 8'h00, "mid_rst_rdata");
        srst_n = 1'b1;
        check("mid_rst_irq", {7'b0, irq}, 8'h00);
        check("mid_rst_gpio_o", gpio_o, 8'h00);
        bus(8'h20, 0, 8'h00, 1, 8'h77, "mid_rst_ram_kept");
        bus(8'hFE, 0, 8'h00, 1, 8'h00, "mid_rst_cnt");
        bus(8'hFF, 0, 8'h00, 1, 8'h00, "mid_rst_ctrl");
        bus(8'hFC, 0, 8'h00, 1, 8'h00, "mid_rst_gpio_rd");
        check("post_rst_irq", {7'b0, irq}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
